// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_arb_pkg: shared types and width helpers for the FIFO write arbiter.
//   arb_state_e : arbiter FSM state (idle / packet transfer)
//   cnt_w()     : credit counter width, holds 0..depth inclusive
//   id_w()      : producer index width
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StXfer
  } arb_state_e;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned DEPTH_DEF   = 8;

  function automatic int unsigned cnt_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned id_w(int unsigned num_req);
    return $clog2(num_req);
  endfunction

  localparam int unsigned CNT_W = $clog2(DEPTH_DEF) + 1;
  localparam int unsigned ID_W  = $clog2(NUM_REQ_DEF);

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: producer handshake, FIFO write port and status bundle.
//   req_valid/req_last/req_data/req_ready : per-producer beat handshake
//   fifo_wr_en/fifo_wr_data               : registered FIFO write port
//   fifo_pop                              : consumer pop, returns one credit
//   credits/busy/grant_id/err_underflow   : status
// Modports: slave = arbiter side, master = producer/FIFO environment side.
interface fifo_write_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_wr_en;
  logic [DATA_W-1:0]         fifo_wr_data;
  logic                      fifo_pop;
  logic [$clog2(DEPTH):0]    credits;
  logic                      busy;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic                      err_underflow;

  modport slave (
    input  req_valid, req_last, req_data, fifo_pop,
    output req_ready, fifo_wr_en, fifo_wr_data, credits, busy, grant_id, err_underflow
  );

  modport master (
    output req_valid, req_last, req_data, fifo_pop,
    input  req_ready, fifo_wr_en, fifo_wr_data, credits, busy, grant_id, err_underflow
  );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search.
//   req_valid : per-producer request
//   rr_ptr    : highest-priority index for this search
//   winner    : first valid index at or after rr_ptr (mod NUM_REQ)
//   any_valid : at least one request present
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IdW-1:0]     rr_ptr,
  output logic [IdW-1:0]     winner,
  output logic               any_valid
);

  always_comb begin
    winner    = '0;
    any_valid = |req_valid;
    // Walk from the farthest offset back to rr_ptr so the nearest valid wins.
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(rr_ptr) + i) % int'(NUM_REQ);
      if (req_valid[idx]) winner = IdW'(idx);
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, packet-locked arbiter in front of a FIFO
// write port, with credit-based overflow protection.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fifo_write_arbiter_if.slave (producer handshake, FIFO write
//              port, pop input, credits/busy/grant_id/err_underflow status)
import fifo_arb_pkg::*;

module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 8
) (
  input logic                 clk,
  input logic                 rst,
  fifo_write_arbiter_if.slave bus
);

  localparam int unsigned CntW = cnt_w(DEPTH);
  localparam int unsigned IdW  = id_w(NUM_REQ);

  arb_state_e        state_q, state_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]    grant_q, grant_d;
  logic [CntW-1:0]   credits_q, credits_d;
  logic              wr_en_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              err_q, err_d;

  logic [IdW-1:0]    winner;
  logic              any_valid;
  logic              have_credit;
  logic              accept;
  logic              pop_ok;
  logic [DATA_W-1:0] grant_data;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req_valid(bus.req_valid),
    .rr_ptr   (rr_ptr_q),
    .winner   (winner),
    .any_valid(any_valid)
  );

  always_comb begin
    have_credit = credits_q != '0;
    grant_data  = bus.req_data[grant_q*DATA_W +: DATA_W];
    accept      = (state_q == StXfer) && have_credit && bus.req_valid[grant_q];
    // A pop with every entry free means the consumer popped an empty FIFO.
    pop_ok      = bus.fifo_pop && (credits_q != CntW'(DEPTH));
    err_d       = err_q | (bus.fifo_pop & ~pop_ok);
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          state_d = StXfer;
          grant_d = winner;
        end
      end
      StXfer: begin
        if (accept && bus.req_last[grant_q]) begin
          state_d  = StIdle;
          rr_ptr_d = (grant_q == IdW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    unique case ({pop_ok, accept})
      2'b10:   credits_d = credits_q + 1'b1;
      2'b01:   credits_d = credits_q - 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  // Only the owner sees ready; it drops as soon as credits run out.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == StXfer) bus.req_ready[grant_q] = have_credit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      credits_q <= CntW'(DEPTH);
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      credits_q <= credits_d;
      wr_en_q   <= accept;
      if (accept) wr_data_q <= grant_data;
      err_q     <= err_d;
    end
  end

  assign bus.fifo_wr_en    = wr_en_q;
  assign bus.fifo_wr_data  = wr_data_q;
  assign bus.credits       = credits_q;
  assign bus.busy          = (state_q == StXfer);
  assign bus.grant_id      = grant_q;
  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: directed scenarios followed by random
// traffic, checked against a behavioural model of ownership, credits and
// the expected FIFO write stream.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int D  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(D)) bus ();

  fifo_write_arbiter #(
    .NUM_REQ(N),
    .DATA_W (DW),
    .DEPTH  (D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus
  logic [N-1:0]  pv;
  logic [N-1:0]  pl;
  logic [31:0]   pd [N];
  bit            pop;

  // Reference model: owner -1 means no packet in progress
  int            m_owner;
  int            m_rr;
  int            m_gid;
  int            m_credits;
  bit            m_err;
  bit            m_wr_en;
  logic [31:0]   m_wr_data;
  int            last_acc;

  logic [31:0]   wr_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_rr      = 0;
    m_gid     = 0;
    m_credits = D;
    m_err     = 1'b0;
    m_wr_en   = 1'b0;
    m_wr_data = '0;
    last_acc  = -1;
  endtask

  task automatic drive();
    bus.req_valid = pv;
    bus.req_last  = pl;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = pd[i];
    bus.fifo_pop  = pop;
  endtask

  task automatic check_regs();
    check("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(m_wr_en));
    check("fifo_wr_data", bus.fifo_wr_data, m_wr_data);
    check("credits", 32'(bus.credits), 32'(m_credits));
    check("busy", 32'(bus.busy), 32'(m_owner >= 0));
    check("grant_id", 32'(bus.grant_id), 32'(m_gid));
    check("err_underflow", 32'(bus.err_underflow), 32'(m_err));
    if (bus.fifo_wr_en) wr_log.push_back(bus.fifo_wr_data);
  endtask

  // One clock: drive, check combinational ready, advance model, check registers.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    bit acc;
    bit pop_ok;
    bit found;
    drive();
    #1;
    exp_ready = '0;
    if (m_owner >= 0 && m_credits > 0) exp_ready[m_owner] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));

    acc      = (m_owner >= 0) && (m_credits > 0) && pv[m_owner];
    last_acc = acc ? m_owner : -1;
    pop_ok   = pop && (m_credits < D);
    if (pop && m_credits == D) m_err = 1'b1;
    m_wr_en = acc;
    if (acc) m_wr_data = pd[m_owner];
    m_credits = m_credits + int'(pop_ok) - int'(acc);
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (pv[c] && !found) begin
          found   = 1'b1;
          m_owner = c;
          m_gid   = c;
        end
      end
    end else if (acc && pl[m_owner]) begin
      m_rr    = (m_owner + 1) % N;
      m_owner = -1;
    end

    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    wr_log.delete();
    check_regs();
    check("rst_ready", 32'(bus.req_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int t;
    int rem [N];
    int seq [N];
    int exp_ord [5];

    pv  = '0;
    pl  = '0;
    pop = 1'b0;
    for (int i = 0; i < N; i++) pd[i] = '0;
    rst = 1'b1;
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Producer 2, three-beat packet
    pv = 4'b0100;
    b  = 0;
    t  = 0;
    while (t < 20 && b < 3) begin
      pd[2] = 32'hA0 + 32'(b);
      pl[2] = (b == 2);
      cycle();
      t++;
      if (last_acc == 2) b++;
    end
    check("p2_beats", 32'(b), 32'd3);
    check("p2_cycles", 32'(t), 32'd4);
    check("p2_credits", 32'(bus.credits), 32'd5);
    check("p2_log_size", 32'(wr_log.size()), 32'd3);
    for (int k = 0; k < 3 && k < wr_log.size(); k++) check("p2_data", wr_log[k], 32'hA0 + 32'(k));
    pv = '0;
    cycle();
    pv = 4'b1100;
    cycle();
    check("rr_after_p2", 32'(bus.grant_id), 32'd3);
    pv = '0;
    cycle();

    // All four producers, one-beat packets, popping whenever something is stored
    do_reset();
    pv = 4'b1111;
    pl = 4'b1111;
    for (int i = 0; i < N; i++) pd[i] = 32'hB0 + 32'(i);
    t = 0;
    while (t < 40 && wr_log.size() < 5) begin
      pop = (m_credits < D);
      cycle();
      t++;
    end
    pop = 1'b0;
    exp_ord = '{0, 1, 2, 3, 0};
    check("rr_log_size", 32'(wr_log.size()), 32'd5);
    for (int k = 0; k < 5 && k < wr_log.size(); k++)
      check("rr_order", wr_log[k], 32'hB0 + 32'(exp_ord[k]));

    // Ten-beat packet without pops: stall at zero credits
    do_reset();
    pv = 4'b0001;
    pl = '0;
    b  = 0;
    t  = 0;
    while (t < 30 && b < 8) begin
      pd[0] = 32'hC0 + 32'(b);
      cycle();
      t++;
      if (last_acc == 0) b++;
    end
    check("fill_beats", 32'(b), 32'd8);
    check("fill_credits", 32'(bus.credits), 32'd0);
    pd[0] = 32'hC0 + 32'(b);
    cycle();
    check("stall_ready", 32'(bus.req_ready), 32'd0);
    pop = 1'b1;
    cycle();
    pop = 1'b0;
    cycle();
    if (last_acc == 0) b++;
    check("ninth_beat", 32'(b), 32'd9);
    check("ninth_credits", 32'(bus.credits), 32'd0);
    pop = 1'b1;
    t   = 0;
    while (t < 30 && (b < 10 || m_credits < D)) begin
      pd[0] = 32'hC0 + 32'(b);
      pl[0] = (b == 9);
      if (b >= 10) pv = '0;
      pop = (m_credits < D);
      cycle();
      t++;
      if (last_acc == 0) b++;
    end
    check("ten_beats", 32'(b), 32'd10);
    pv  = '0;
    pl  = '0;
    pop = 1'b0;

    // Pop and accept together at three credits; pop at full credits
    do_reset();
    pv = 4'b0010;
    b  = 0;
    t  = 0;
    while (t < 20 && b < 5) begin
      pd[1] = 32'hD0 + 32'(b);
      cycle();
      t++;
      if (last_acc == 1) b++;
    end
    check("five_credits", 32'(bus.credits), 32'd3);
    pop = 1'b1;
    pd[1] = 32'hD5;
    cycle();
    check("pop_acc_beat", 32'(last_acc), 32'd1);
    check("pop_acc_credits", 32'(bus.credits), 32'd3);
    pop   = 1'b0;
    pl[1] = 1'b1;
    pd[1] = 32'hD6;
    cycle();
    pv = '0;
    pl = '0;
    t  = 0;
    while (t < 20 && m_credits < D) begin
      pop = 1'b1;
      cycle();
      t++;
    end
    check("drained", 32'(bus.credits), 32'd8);
    check("no_err_yet", 32'(bus.err_underflow), 32'd0);
    pop = 1'b1;
    cycle();
    check("underflow_set", 32'(bus.err_underflow), 32'd1);
    check("underflow_credits", 32'(bus.credits), 32'd8);
    pop = 1'b0;
    repeat (3) cycle();
    check("underflow_sticky", 32'(bus.err_underflow), 32'd1);
    do_reset();
    check("underflow_cleared", 32'(bus.err_underflow), 32'd0);

    // Reset during beat 2 of a four-beat packet from producer 1
    pv = 4'b0010;
    b  = 0;
    t  = 0;
    while (t < 20 && b < 1) begin
      pd[1] = 32'hE0 + 32'(b);
      cycle();
      t++;
      if (last_acc == 1) b++;
    end
    pd[1] = 32'hE1;
    rst   = 1'b1;
    drive();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pv  = '0;
    model_reset();
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_credits", 32'(bus.credits), 32'd8);
    check("midrst_grant", 32'(bus.grant_id), 32'd0);
    check("midrst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    check("midrst_ready", 32'(bus.req_ready), 32'd0);

    // Random traffic: random packet lengths, valid gaps and pops
    for (int i = 0; i < N; i++) begin
      rem[i] = int'($urandom_range(1, 4));
      seq[i] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        pv[i] = ($urandom % 4) != 0;
        pl[i] = (rem[i] == 1);
        pd[i] = (32'(i) << 24) | 32'(seq[i]);
      end
      pop = ($urandom % 3) == 0;
      cycle();
      if (last_acc >= 0) begin
        seq[last_acc]++;
        rem[last_acc]--;
        if (rem[last_acc] == 0) rem[last_acc] = int'($urandom_range(1, 4));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin, packet-locked arbiter that shares the write port of one DEPTH-entry FIFO buffer among NUM_REQ producers. It grants one producer at a time for a whole packet and tracks FIFO space with a credit counter so the FIFO can never overflow. It registers the FIFO write strobe and data, and takes the consumer-side pop as an input to return credits. It sits directly in front of the FIFO buffer; the FIFO's own full flag is not used.

## Interface
- NUM_REQ, 4, number of producers (2..8)
- DATA_W, 32, beat width
- DEPTH, 8, FIFO entries; power of two
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-producer beat valid
- req_last  in  NUM_REQ  per-producer last beat of packet
- req_data  in  NUM_REQ*DATA_W  producer i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  combinational; beat accepted when valid&ready
- fifo_wr_en  out  1  registered FIFO write strobe
- fifo_wr_data  out  DATA_W  registered FIFO write data
- fifo_pop  in  1  one FIFO entry consumed this cycle; returns one credit
- credits  out  $clog2(DEPTH)+1  free FIFO entries
- busy  out  1  state==XFER
- grant_id  out  $clog2(NUM_REQ)  current/last owner
- err_underflow  out  1  sticky; fifo_pop seen with credits==DEPTH

## Operation
- FSM IDLE/XFER. IDLE: if any req_valid, pick winner by round-robin from rr_ptr (search rr_ptr, rr_ptr+1, … mod NUM_REQ); next cycle XFER, grant_id=winner. No beat is accepted in IDLE.
- XFER: req_ready[grant_id] = (credits!=0); all other ready bits 0. Each accepted beat: fifo_wr_en=1, fifo_wr_data=beat next cycle, credits-1.
- Accepted beat with req_last: rr_ptr=grant_id+1 mod NUM_REQ, go IDLE. Owner dropping valid mid-packet keeps lock (no timeout).
- Credits: +1 on fifo_pop, -1 on accepted beat; both same cycle → unchanged. fifo_pop at credits==DEPTH: credits unchanged, err_underflow set until rst.
- Width rule: credits range 0..DEPTH inclusive, hence one extra bit.
- Reset values: state IDLE, rr_ptr 0, grant_id 0, credits DEPTH, fifo_wr_en 0, fifo_wr_data 0, busy 0, err_underflow 0, req_ready all 0.

## Timing
- Arbitration: valid seen in IDLE at cycle N → ready earliest N+1.
- Beat accepted cycle N → fifo_wr_en/data at N+1 (1-cycle latency).
- Back-to-back: one beat per cycle while credits!=0; packet-to-packet gap one IDLE cycle.
- credits==0: ready low same cycle; a fifo_pop at cycle N makes ready high at N+1.
- rst mid-packet: next cycle in reset state; pending beats dropped, no partial-packet recovery.

## Structure
- Package fifo_arb_pkg: state enum {IDLE, XFER}; helper constants CNT_W=$clog2(DEPTH)+1, ID_W=$clog2(NUM_REQ).
- Sub-module rr_pick: combinational rotate-and-find-first over req_valid given rr_ptr; outputs winner index and any_valid. All state stays in fifo_write_arbiter.

## Test plan
- Reset, then idle: credits=8, req_ready=0, fifo_wr_en=0, busy=0, err_underflow=0.
- Producer 2 sends 3-beat packet 0xA0,0xA1,0xA2(last): ready at cycle+1, fifo_wr_data shows A0..A2 on three consecutive cycles, credits 8→5, then IDLE, rr_ptr=3.
- All four valid continuously, 1-beat packets, pops every cycle: grant order 0,1,2,3,0; no interleaving of beats within a packet.
- 10-beat packet, no pops: 8 beats accepted, ready drops at credits=0; one pop → ninth beat accepted next cycle, credits stays 0.
- Pop and accept same cycle at credits=3 → credits remains 3; pop at credits=8 → credits 8, err_underflow=1 sticky until rst.
- rst asserted mid-packet (producer 1, beat 2 of 4): next cycle IDLE, credits=8, grant_id=0, fifo_wr_en=0.
